// File: rtl/phy_rx_link_ctrl.sv
// rtl/phy_rx_link_ctrl.sv - PHY RX link controller: COM symbol lock, COM/IDL filtering, 4-lane round-robin steering
//
// Ports:
//   clk4f       byte clock, all state on the rising edge
//   reset       synchronous, active-high
//   in_byte     byte from the serial-to-parallel stage
//   in_valid    qualifies in_byte; low cycles carry no symbol
//   data_out    forwarded data byte (held when data_valid is low)
//   data_valid  data_out qualifier
//   lane_sel    lane of the byte on data_out (held when data_valid is low)
//   lane_valid  one-hot of lane_sel while data_valid is high, else zero
//   active      high while the link is locked
//   lock_lost   one-cycle pulse when lock is dropped on COM timeout
//   state       0=SEARCH 1=LOCKING 2=ACTIVE
module phy_rx_link_ctrl #(
    parameter logic [7:0] COM_SYM    = 8'hBC,
    parameter logic [7:0] IDL_SYM    = 8'h7C,
    parameter int         LOCK_COUNT = 4,
    parameter int         TIMEOUT    = 64
) (
    input  logic       clk4f,
    input  logic       reset,
    input  logic [7:0] in_byte,
    input  logic       in_valid,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic [1:0] lane_sel,
    output logic [3:0] lane_valid,
    output logic       active,
    output logic       lock_lost,
    output logic [1:0] state
);

    localparam int CW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_LOCKING = 2'd1,
        ST_ACTIVE  = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  com_cnt_q, com_cnt_d, com_cnt_inc;
    logic [TW-1:0]  timer_q, timer_d, timer_inc;
    logic [1:0]     next_lane_q, next_lane_d;
    logic [7:0]     data_out_q, data_out_d;
    logic           data_valid_q, data_valid_d;
    logic [1:0]     lane_sel_q, lane_sel_d;
    logic [3:0]     lane_valid_q, lane_valid_d;
    logic           active_q, active_d;
    logic           lock_lost_q, lock_lost_d;

    logic is_com, is_idl, is_data;

    assign is_com  = in_valid && (in_byte == COM_SYM);
    assign is_idl  = in_valid && (in_byte == IDL_SYM);
    assign is_data = in_valid && !is_com && !is_idl;

    assign com_cnt_inc = com_cnt_q + 1'b1;
    assign timer_inc   = timer_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        com_cnt_d    = com_cnt_q;
        timer_d      = timer_q;
        next_lane_d  = next_lane_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        lane_sel_d   = lane_sel_q;
        lane_valid_d = 4'b0000;
        lock_lost_d  = 1'b0;

        case (state_q)
            ST_LOCKING: begin
                if (is_com) begin
                    com_cnt_d = com_cnt_inc;
                    if (com_cnt_inc == CW'(LOCK_COUNT)) begin
                        state_d     = ST_ACTIVE;
                        timer_d     = '0;
                        next_lane_d = 2'd0;
                    end
                end else if (in_valid) begin
                    // Any non-COM symbol breaks the consecutive run.
                    com_cnt_d = '0;
                    state_d   = ST_SEARCH;
                end
            end

            ST_ACTIVE: begin
                if (is_com) begin
                    timer_d = '0;
                end else if (timer_inc == TW'(TIMEOUT)) begin
                    // Timeout wins over a DATA byte in the same cycle: it is dropped.
                    state_d     = ST_SEARCH;
                    lock_lost_d = 1'b1;
                    com_cnt_d   = '0;
                    next_lane_d = 2'd0;
                    timer_d     = '0;
                end else begin
                    timer_d = timer_inc;
                    if (is_data) begin
                        data_out_d   = in_byte;
                        data_valid_d = 1'b1;
                        lane_sel_d   = next_lane_q;
                        lane_valid_d = 4'b0001 << next_lane_q;
                        next_lane_d  = next_lane_q + 2'd1;
                    end
                end
            end

            // SEARCH, and the unused encoding which behaves as SEARCH.
            default: begin
                state_d = ST_SEARCH;
                if (is_com) begin
                    com_cnt_d = CW'(1);
                    if (LOCK_COUNT == 1) begin
                        state_d     = ST_ACTIVE;
                        timer_d     = '0;
                        next_lane_d = 2'd0;
                    end else begin
                        state_d = ST_LOCKING;
                    end
                end
            end
        endcase

        active_d = (state_d == ST_ACTIVE);
    end

    always_ff @(posedge clk4f) begin
        if (reset) begin
            state_q      <= ST_SEARCH;
            com_cnt_q    <= '0;
            timer_q      <= '0;
            next_lane_q  <= 2'd0;
            data_out_q   <= 8'h00;
            data_valid_q <= 1'b0;
            lane_sel_q   <= 2'd0;
            lane_valid_q <= 4'b0000;
            active_q     <= 1'b0;
            lock_lost_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            com_cnt_q    <= com_cnt_d;
            timer_q      <= timer_d;
            next_lane_q  <= next_lane_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            lane_sel_q   <= lane_sel_d;
            lane_valid_q <= lane_valid_d;
            active_q     <= active_d;
            lock_lost_q  <= lock_lost_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign lane_sel   = lane_sel_q;
    assign lane_valid = lane_valid_q;
    assign active     = active_q;
    assign lock_lost  = lock_lost_q;
    assign state      = state_q;

endmodule
